// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared register/datapath widths and scoreboard-entry field widths
package pipe_hazard_ctrl_pkg;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CPU_WIDTH = 64;
  localparam int SB_VALID_W = 1;
  localparam int SB_WEN_W = 1;
  localparam int SB_LOAD_W = 1;
  localparam int SB_READY_W = 1;
  localparam int SB_RD_W = REG_ADDR_WIDTH;
  localparam int SB_DATA_W = CPU_WIDTH;
endpackage

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// pipe_fwd_match: youngest-entry priority matcher for one source (i_used/i_addr vs scoreboard -> o_hit/o_hazard/o_data)
module pipe_fwd_match
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN = CPU_WIDTH,
  parameter int AW = REG_ADDR_WIDTH,
  parameter int DEPTH = 3
)(
  input  logic                       i_used,
  input  logic [AW-1:0]              i_addr,
  input  logic [DEPTH-1:0]           i_valid,
  input  logic [DEPTH-1:0]           i_wen,
  input  logic [DEPTH-1:0]           i_ready,
  input  logic [DEPTH-1:0][AW-1:0]   i_rd,
  input  logic [DEPTH-1:0][XLEN-1:0] i_data,
  output logic                       o_hit,
  output logic                       o_hazard,
  output logic [XLEN-1:0]            o_data
);
  always_comb begin
    o_hit = 1'b0;
    o_hazard = 1'b0;
    o_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--)
      if (i_used && i_addr != '0 && i_valid[k] && i_wen[k] && i_rd[k] == i_addr) begin
        o_hit = i_ready[k];
        o_hazard = !i_ready[k];
        o_data = i_ready[k] ? i_data[k] : '0;
      end
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: scoreboard-based forwarding, load-use stall, redirect flush, write-back and stall counter
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN = CPU_WIDTH,
  parameter int AW = REG_ADDR_WIDTH,
  parameter int NSRC = 2,
  parameter int DEPTH = 3,
  parameter int LSTAGE = 2,
  parameter int CW = 32
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_rs_addr,
  input  logic [NSRC-1:0]      id_rs_used,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_wen,
  input  logic                 id_is_load,
  input  logic [XLEN-1:0]      ex_result,
  input  logic                 ex_redirect,
  input  logic                 mem_ready,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 stall,
  output logic                 flush,
  output logic [NSRC-1:0]      fwd_hit,
  output logic [NSRC*XLEN-1:0] fwd_data,
  output logic                 wb_wen,
  output logic [AW-1:0]        wb_addr,
  output logic [XLEN-1:0]      wb_data,
  output logic [CW-1:0]        stall_cnt
);
  logic [DEPTH-1:0] r_valid, r_wen, r_load, r_ready, w_ready;
  logic [DEPTH-1:0][AW-1:0] r_rd;
  logic [DEPTH-1:0][XLEN-1:0] r_data, w_data;
  logic [NSRC-1:0] w_hazard;
  logic [CW-1:0] r_stall_cnt;
  logic w_cap;
  always_comb begin
    w_ready = r_ready;
    w_data = r_data;
    w_ready[0] = r_ready[0] | !r_load[0];
    w_data[0] = ex_result;
  end
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    pipe_fwd_match #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) u_match (
      .i_used(id_rs_used[i]),
      .i_addr(id_rs_addr[i*AW +: AW]),
      .i_valid(r_valid),
      .i_wen(r_wen),
      .i_ready(w_ready),
      .i_rd(r_rd),
      .i_data(w_data),
      .o_hit(fwd_hit[i]),
      .o_hazard(w_hazard[i]),
      .o_data(fwd_data[i*XLEN +: XLEN])
    );
  end
  assign flush = ex_redirect & mem_ready & r_valid[0];
  assign stall = (id_valid & |w_hazard & !flush) | !mem_ready;
  assign w_cap = id_valid & !stall & !flush;
  assign wb_wen = r_valid[DEPTH-1] & r_wen[DEPTH-1] & mem_ready & |r_rd[DEPTH-1];
  assign wb_addr = r_rd[DEPTH-1];
  assign wb_data = r_data[DEPTH-1];
  assign stall_cnt = r_stall_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_wen <= '0;
      r_load <= '0;
      r_ready <= '0;
      r_rd <= '0;
      r_data <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (mem_ready) begin
        for (int k = 1; k < DEPTH; k++) begin
          r_valid[k] <= r_valid[k-1];
          r_wen[k] <= r_wen[k-1];
          r_load[k] <= r_load[k-1];
          r_rd[k] <= r_rd[k-1];
          r_data[k] <= (k == LSTAGE && r_load[k-1]) ? mem_rdata : (k == 1) ? ex_result : r_data[k-1];
          r_ready[k] <= (k == LSTAGE && r_load[k-1]) || ((k == 1) ? !r_load[0] : r_ready[k-1]);
        end
        r_valid[0] <= w_cap;
        r_wen[0] <= w_cap & id_wen;
        r_load[0] <= w_cap & id_is_load;
        r_rd[0] <= w_cap ? id_rd : '0;
        r_ready[0] <= 1'b0;
        r_data[0] <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table, corner sequences and randomized model check of pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  localparam int XLEN = 64, AW = 5, NSRC = 2, DEPTH = 3, LSTAGE = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic id_valid = 1'b0, id_wen = 1'b0, id_is_load = 1'b0, ex_redirect = 1'b0, mem_ready = 1'b1;
  logic [NSRC*AW-1:0] id_rs_addr = '0;
  logic [NSRC-1:0] id_rs_used = '0;
  logic [AW-1:0] id_rd = '0;
  logic [XLEN-1:0] ex_result = '0, mem_rdata = '0;
  logic stall, flush, wb_wen, s_stall, s_flush, s_wb_wen;
  logic [NSRC-1:0] fwd_hit, s_fwd_hit;
  logic [NSRC*XLEN-1:0] fwd_data, s_fwd_data;
  logic [AW-1:0] wb_addr, s_wb_addr;
  logic [XLEN-1:0] wb_data, s_wb_data;
  logic [31:0] stall_cnt;
  logic [3:0] s_stall_cnt;
  always #5 clk = ~clk;
  pipe_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .ex_result(ex_result),
    .ex_redirect(ex_redirect), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(stall),
    .flush(flush), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .wb_wen(wb_wen), .wb_addr(wb_addr),
    .wb_data(wb_data), .stall_cnt(stall_cnt)
  );
  pipe_hazard_ctrl #(.CW(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .ex_result(ex_result),
    .ex_redirect(ex_redirect), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .stall(s_stall),
    .flush(s_flush), .fwd_hit(s_fwd_hit), .fwd_data(s_fwd_data), .wb_wen(s_wb_wen), .wb_addr(s_wb_addr),
    .wb_data(s_wb_data), .stall_cnt(s_stall_cnt)
  );
  typedef struct {
    logic [63:0] v, rs0, u0, rd, wen, ld, exr, redir, mrdy, mrd;
    logic [63:0] e_stall, e_flush, e_hit, e_d0, e_wb, e_wba, e_wbd, e_cnt;
  } vec_t;
  typedef struct {
    bit valid;
    bit [4:0] rd;
    bit wen, ld, have;
    bit [63:0] val;
  } rec_t;
  vec_t tbl[16];
  vec_t tv;
  rec_t q[$];
  int checks = 0, errors = 0, cnt = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic do_reset();
    id_valid = 1'b0; id_wen = 1'b0; id_is_load = 1'b0; ex_redirect = 1'b0; mem_ready = 1'b1;
    id_rs_used = '0; rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask
  function automatic void ref_src(input bit [4:0] a, input bit u, output bit h, output bit z, output bit [63:0] d);
    h = 0; z = 0; d = 0;
    if (u && a != 0)
      for (int j = 0; j < q.size(); j++)
        if (q[j].valid && q[j].wen && q[j].rd == a) begin
          if (j == 0 && !q[j].ld) begin h = 1; d = ex_result; end
          else if (q[j].have) begin h = 1; d = q[j].val; end
          else z = 1;
          break;
        end
  endfunction
  initial begin
    //          v rs0 u0 rd wen ld exr     rd mr mrd       st fl hit d0       wb wba wbd      cnt
    tbl[0]  = '{1, 0, 0, 5, 1, 0, 0,      0, 1, 0,        0, 0, 0, 0,       0, 0, 0,       0};
    tbl[1]  = '{1, 5, 1, 0, 0, 0, 'h10,   0, 1, 0,        0, 0, 1, 'h10,    0, 0, 0,       0};
    tbl[2]  = '{1, 5, 1, 6, 1, 1, 'h99,   0, 1, 0,        0, 0, 1, 'h10,    0, 0, 0,       0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 'h55,   0, 1, 0,        0, 0, 0, 0,       1, 5, 'h10,    0};
    tbl[4]  = '{1, 6, 1, 7, 1, 0, 0,      0, 1, 'hDEAD,   1, 0, 0, 0,       0, 0, 0,       0};
    tbl[5]  = '{1, 6, 1, 7, 1, 0, 0,      0, 1, 0,        0, 0, 1, 'hDEAD,  1, 6, 'hDEAD,  1};
    tbl[6]  = '{1, 0, 0, 7, 1, 0, 'h1,    0, 1, 0,        0, 0, 0, 0,       0, 0, 0,       1};
    tbl[7]  = '{1, 7, 1, 0, 1, 0, 'h2,    0, 1, 0,        0, 0, 1, 'h2,     0, 0, 0,       1};
    tbl[8]  = '{1, 0, 1, 8, 1, 1, 'h77,   0, 1, 0,        0, 0, 0, 0,       1, 7, 'h1,     1};
    tbl[9]  = '{1, 8, 1, 9, 1, 0, 'h5,    1, 1, 0,        0, 1, 0, 0,       1, 7, 'h2,     1};
    tbl[10] = '{1, 8, 1, 9, 1, 0, 0,      1, 1, 'hBEEF,   1, 0, 0, 0,       0, 0, 0,       1};
    tbl[11] = '{1, 8, 1, 9, 1, 0, 0,      1, 0, 0,        1, 0, 1, 'hBEEF,  0, 0, 0,       2};
    tbl[12] = '{1, 8, 1, 9, 1, 0, 0,      1, 0, 0,        1, 0, 1, 'hBEEF,  0, 0, 0,       3};
    tbl[13] = '{1, 8, 1, 9, 1, 0, 0,      1, 0, 0,        1, 0, 1, 'hBEEF,  0, 0, 0,       4};
    tbl[14] = '{1, 8, 1, 9, 1, 0, 0,      1, 0, 0,        1, 0, 1, 'hBEEF,  0, 0, 0,       5};
    tbl[15] = '{1, 8, 1, 9, 1, 0, 0,      0, 1, 0,        0, 0, 1, 'hBEEF,  1, 8, 'hBEEF,  6};
    do_reset();
    #1;
    chk("rst_stall", 64'(stall), 0);
    chk("rst_flush", 64'(flush), 0);
    chk("rst_hit", 64'(fwd_hit), 0);
    chk("rst_data_lo", fwd_data[63:0], 0);
    chk("rst_data_hi", fwd_data[127:64], 0);
    chk("rst_wb_wen", 64'(wb_wen), 0);
    chk("rst_wb_addr", 64'(wb_addr), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_cnt", 64'(stall_cnt), 0);
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      tv = tbl[r];
      id_valid = tv.v[0]; id_rs_addr = {5'd0, tv.rs0[4:0]}; id_rs_used = {1'b0, tv.u0[0]};
      id_rd = tv.rd[4:0]; id_wen = tv.wen[0]; id_is_load = tv.ld[0]; ex_result = tv.exr;
      ex_redirect = tv.redir[0]; mem_ready = tv.mrdy[0]; mem_rdata = tv.mrd;
      #1;
      chk($sformatf("t%0d_stall", r), 64'(stall), tv.e_stall);
      chk($sformatf("t%0d_flush", r), 64'(flush), tv.e_flush);
      chk($sformatf("t%0d_hit0", r), 64'(fwd_hit[0]), tv.e_hit);
      chk($sformatf("t%0d_hit1", r), 64'(fwd_hit[1]), 0);
      chk($sformatf("t%0d_data0", r), fwd_data[63:0], tv.e_d0);
      chk($sformatf("t%0d_wb_wen", r), 64'(wb_wen), tv.e_wb);
      if (tv.e_wb[0]) begin
        chk($sformatf("t%0d_wb_addr", r), 64'(wb_addr), tv.e_wba);
        chk($sformatf("t%0d_wb_data", r), wb_data, tv.e_wbd);
      end
      chk($sformatf("t%0d_cnt", r), 64'(stall_cnt), tv.e_cnt);
      chk($sformatf("t%0d_sat_cnt", r), 64'(s_stall_cnt), tv.e_cnt);
    end
    do_reset();
    q = {};
    repeat (DEPTH) q.push_back('{default: 0});
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      bit h[NSRC], z[NSRC], e_flush, e_stall, e_wb, cap;
      bit [63:0] d[NSRC];
      rec_t n;
      @(negedge clk);
      id_valid = ($urandom_range(0, 9) < 8);
      id_rs_addr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_rs_used = 2'($urandom);
      id_rd = 5'($urandom_range(0, 3));
      id_wen = 1'($urandom);
      id_is_load = ($urandom_range(0, 9) < 3);
      ex_result = {$urandom, $urandom};
      ex_redirect = ($urandom_range(0, 9) < 2);
      mem_ready = ($urandom_range(0, 9) < 8);
      mem_rdata = {$urandom, $urandom};
      #1;
      for (int s = 0; s < NSRC; s++) ref_src(id_rs_addr[s*AW +: AW], id_rs_used[s], h[s], z[s], d[s]);
      e_flush = ex_redirect && mem_ready && q[0].valid;
      e_stall = (id_valid && (z[0] || z[1]) && !e_flush) || !mem_ready;
      e_wb = q[DEPTH-1].valid && q[DEPTH-1].wen && mem_ready && q[DEPTH-1].rd != 0;
      chk("rnd_stall", 64'(stall), 64'(e_stall));
      chk("rnd_flush", 64'(flush), 64'(e_flush));
      for (int s = 0; s < NSRC; s++) begin
        chk("rnd_hit", 64'(fwd_hit[s]), 64'(h[s]));
        chk("rnd_data", fwd_data[s*XLEN +: XLEN], d[s]);
      end
      chk("rnd_wb_wen", 64'(wb_wen), 64'(e_wb));
      if (e_wb) begin
        chk("rnd_wb_addr", 64'(wb_addr), 64'(q[DEPTH-1].rd));
        chk("rnd_wb_data", wb_data, q[DEPTH-1].val);
      end
      chk("rnd_cnt", 64'(stall_cnt), 64'(cnt));
      chk("rnd_sat_cnt", 64'(s_stall_cnt), 64'(cnt > 15 ? 15 : cnt));
      if (mem_ready) begin
        for (int j = 0; j < q.size(); j++) begin
          n = q[j];
          if (j == 0 && !n.ld) begin n.val = ex_result; n.have = 1; end
          if (j + 1 == LSTAGE && n.ld) begin n.val = mem_rdata; n.have = 1; end
          q[j] = n;
        end
        cap = id_valid && !e_stall && !e_flush;
        n = '{default: 0};
        if (cap) begin n.valid = 1; n.rd = id_rd; n.wen = id_wen; n.ld = id_is_load; end
        q.push_front(n);
        void'(q.pop_back());
      end
      if (e_stall) cnt++;
    end
    do_reset();
    @(negedge clk);
    id_valid = 1'b1; id_rd = 5'd9; id_wen = 1'b1; id_is_load = 1'b1; id_rs_used = '0;
    @(negedge clk);
    id_rs_addr = {5'd0, 5'd9}; id_rs_used = 2'b01; id_rd = '0; id_wen = 1'b0; id_is_load = 1'b0; mem_ready = 1'b0;
    #1 chk("midload_stall", 64'(stall), 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("post_rst_wb_wen", 64'(wb_wen), 0);
      chk("post_rst_hit", 64'(fwd_hit), 0);
      chk("post_rst_stall", 64'(stall), 0);
      @(negedge clk);
    end
    chk("post_rst_cnt", 64'(stall_cnt), 0);
    id_valid = 1'b0; mem_ready = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("busy_wb_wen", 64'(wb_wen), 0);
    chk("busy_cnt", 64'(stall_cnt), 20);
    chk("sat_cnt", 64'(s_stall_cnt), 15);
    mem_ready = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
